// File: rtl/operand_reg_if.sv
// Operand register bus: control/data toward the register, value and flags back.
// Plain wires only; no clocking or protocol state lives here.
interface operand_reg_if #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 4
);
  logic               clr;
  logic               en;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   d;
  logic               ser_in;
  logic [DIGIT_W-1:0] digit;
  logic [WIDTH-1:0]   q;
  logic               carry_out;
  logic               ovf;
  logic               zero;

  modport master (
    output clr, en, mode, d, ser_in, digit,
    input  q, carry_out, ovf, zero
  );

  modport slave (
    input  clr, en, mode, d, ser_in, digit,
    output q, carry_out, ovf, zero
  );
endinterface

// File: rtl/operand_reg.sv
// Calculator operand register: load/shift/rotate/inc/dec/digit-entry with carry and sticky overflow.
// Latency 1 clk edge for q/carry_out/ovf (zero is combinational); no backpressure, en gates each op.
module operand_reg #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  operand_reg_if.slave  bus
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROTL  = 3'b100,
    M_INC   = 3'b101,
    M_DEC   = 3'b110,
    M_DIGIT = 3'b111
  } mode_e;

  localparam int W1 = WIDTH + 1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             carry_r;
  logic             carry_nxt;
  logic             ovf_r;
  logic             ovf_nxt;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;
  logic             digit_lost;
  mode_e            mode_sel;

  // One extra bit on the arithmetic catches carry/borrow without a separate compare.
  assign inc_sum    = {1'b0, q_r} + W1'(1);
  assign dec_diff   = {1'b0, q_r} - W1'(1);
  assign digit_lost = |q_r[WIDTH-1:WIDTH-DIGIT_W];
  assign mode_sel   = mode_e'(bus.mode);

  always_comb begin
    q_nxt     = q_r;
    carry_nxt = carry_r;
    ovf_nxt   = ovf_r;
    if (bus.clr) begin
      q_nxt     = '0;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
    end else if (bus.en) begin
      case (mode_sel)
        M_HOLD: ;
        M_LOAD: begin
          q_nxt     = bus.d;
          carry_nxt = 1'b0;
          ovf_nxt   = 1'b0;
        end
        M_SHL: begin
          q_nxt     = {q_r[WIDTH-2:0], bus.ser_in};
          carry_nxt = q_r[WIDTH-1];
        end
        M_SHR: begin
          q_nxt     = {bus.ser_in, q_r[WIDTH-1:1]};
          carry_nxt = q_r[0];
        end
        M_ROTL: begin
          q_nxt     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          carry_nxt = q_r[WIDTH-1];
        end
        M_INC: begin
          q_nxt     = inc_sum[WIDTH-1:0];
          carry_nxt = inc_sum[WIDTH];
          ovf_nxt   = ovf_r | inc_sum[WIDTH];
        end
        M_DEC: begin
          q_nxt     = dec_diff[WIDTH-1:0];
          carry_nxt = dec_diff[WIDTH];
          ovf_nxt   = ovf_r | dec_diff[WIDTH];
        end
        M_DIGIT: begin
          q_nxt     = {q_r[WIDTH-DIGIT_W-1:0], bus.digit};
          carry_nxt = 1'b0;
          ovf_nxt   = ovf_r | digit_lost;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      q_r     <= q_nxt;
      carry_r <= carry_nxt;
      ovf_r   <= ovf_nxt;
    end
  end

  assign bus.q         = q_r;
  assign bus.carry_out = carry_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = (q_r == '0);

endmodule

// File: tb/tb_operand_reg.sv
// Self-checking bench for operand_reg: directed scenarios plus randomized ops against an arithmetic model.
module tb_operand_reg;
  localparam int WIDTH   = 8;
  localparam int DIGIT_W = 4;
  localparam int MOD     = 1 << WIDTH;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // Reference state kept as plain integers.
  int   mq;
  int   mc;
  int   mo;

  operand_reg_if #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) bus ();

  operand_reg #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_step(input bit c, input bit e, input int m,
                                     input int dd, input int s, input int dg);
    if (c) begin
      mq = 0; mc = 0; mo = 0;
    end else if (e) begin
      case (m)
        1: begin mq = dd; mc = 0; mo = 0; end
        2: begin mc = (mq >= MOD / 2) ? 1 : 0; mq = (mq * 2 + s) % MOD; end
        3: begin mc = mq % 2; mq = s * (MOD / 2) + mq / 2; end
        4: begin mc = (mq >= MOD / 2) ? 1 : 0; mq = (mq * 2) % MOD + mc; end
        5: begin mc = (mq == MOD - 1) ? 1 : 0; mq = (mq + 1) % MOD; if (mc != 0) mo = 1; end
        6: begin mc = (mq == 0) ? 1 : 0; mq = (mq + MOD - 1) % MOD; if (mc != 0) mo = 1; end
        7: begin
          if (mq / (MOD >> DIGIT_W) != 0) mo = 1;
          mq = (mq * (1 << DIGIT_W)) % MOD + dg;
          mc = 0;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"},     32'(bus.q),         32'(mq));
    chk({tag, ".carry"}, 32'(bus.carry_out), 32'(mc));
    chk({tag, ".ovf"},   32'(bus.ovf),       32'(mo));
    chk({tag, ".zero"},  32'(bus.zero),      32'((mq == 0) ? 1 : 0));
  endtask

  // Drive one cycle's inputs, take the edge, then compare 1ns later.
  task automatic drive(input string tag, input bit c, input bit e, input logic [2:0] m,
                       input logic [WIDTH-1:0] dd, input bit s, input logic [DIGIT_W-1:0] dg);
    bus.clr    = c;
    bus.en     = e;
    bus.mode   = m;
    bus.d      = dd;
    bus.ser_in = s;
    bus.digit  = dg;
    @(posedge clk);
    model_step(c, e, int'(m), int'(dd), int'(s), int'(dg));
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and check outputs before any clock arrives.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    mq = 0; mc = 0; mo = 0;
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mq = 0; mc = 0; mo = 0;
    bus.clr = 1'b0; bus.en = 1'b0; bus.mode = 3'd0;
    bus.d = '0; bus.ser_in = 1'b0; bus.digit = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;
    #1;

    // Load then shift
    drive("ld_a5", 0, 1, 3'b001, 8'hA5, 0, 4'd0);
    drive("shl",   0, 1, 3'b010, 8'h00, 1, 4'd0);
    chk("shl_const", 32'(bus.q), 32'h4B);
    drive("shr",   0, 1, 3'b011, 8'h00, 0, 4'd0);
    chk("shr_const", 32'(bus.q), 32'h25);
    chk("shr_carry", 32'(bus.carry_out), 32'd1);

    // Increment wrap, decrement borrow, load clears ovf
    drive("ld_ff", 0, 1, 3'b001, 8'hFF, 0, 4'd0);
    drive("inc_wrap", 0, 1, 3'b101, 8'h00, 0, 4'd0);
    chk("inc_wrap_ovf", 32'(bus.ovf), 32'd1);
    drive("dec_wrap", 0, 1, 3'b110, 8'h00, 0, 4'd0);
    chk("dec_wrap_q", 32'(bus.q), 32'hFF);
    drive("ld_10", 0, 1, 3'b001, 8'h10, 0, 4'd0);
    chk("ld_clears_ovf", 32'(bus.ovf), 32'd0);

    // Digit entry
    drive("clr", 1, 0, 3'b000, 8'h00, 0, 4'd0);
    drive("dig1", 0, 1, 3'b111, 8'h00, 0, 4'd1);
    drive("dig2", 0, 1, 3'b111, 8'h00, 0, 4'd2);
    drive("dig3", 0, 1, 3'b111, 8'h00, 0, 4'd3);
    chk("dig3_q",   32'(bus.q),   32'h23);
    chk("dig3_ovf", 32'(bus.ovf), 32'd1);

    // Enable low holds; clear beats enable
    drive("ld_5a", 0, 1, 3'b001, 8'h5A, 0, 4'd0);
    drive("en_low", 0, 0, 3'b001, 8'hFF, 0, 4'd0);
    chk("en_low_q", 32'(bus.q), 32'h5A);
    drive("clr_en", 1, 1, 3'b101, 8'h00, 0, 4'd0);

    // Rotate then asynchronous reset
    drive("ld_81", 0, 1, 3'b001, 8'h81, 0, 4'd0);
    drive("rotl",  0, 1, 3'b100, 8'h00, 0, 4'd0);
    chk("rotl_const", 32'(bus.q), 32'h03);
    mid_reset("async_rst");
    drive("post_rst_ld", 0, 1, 3'b001, 8'hC3, 0, 4'd0);

    // Randomized ops, with occasional clear/enable-low and mid-cycle resets
    for (int i = 0; i < 1500; i++) begin
      bit c;
      bit e;
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 7) != 0);
      drive("rand", c, e, 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 4'($urandom));
      if ($urandom_range(0, 99) == 0) mid_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
